alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised successor to the combinational 64-bit ALU.
- Registered result and zero flag; valid/ready handshakes on input and output.
- Adds signed set-less-than, NOR and a multi-cycle shift-add multiply; flags illegal opcodes.
- Sits between the decode/operand-fetch stage and writeback of the CPU datapath.

Parameters:
- WIDTH, 64, operand/result width in bits (>=2).
- SEL_W, 4, opcode width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operands/opcode valid.
- in_ready  output  1  block accepts operation this cycle.
- select  input  SEL_W  opcode.
- input1  input  WIDTH  operand A.
- input2  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- result  output  WIDTH  registered result.
- zero  output  1  1 iff result == 0.
- illegal  output  1  opcode not in the supported set.
- busy  output  1  multiply in progress.

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, out_valid=0, result=0, zero=0, illegal=0, busy=0, multiply counter=0. Reset during a multiply aborts it and no result is produced.
- Opcodes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD (mod 2^WIDTH)
  - 0110 SUB (mod 2^WIDTH)
  - 0111 SLT: result=1 if signed input1<input2, else 0.
  - 1100 NOR
  - 1000 MUL: low WIDTH bits of the unsigned product.
  - Any other code: result=0, zero=1, illegal=1, 1-cycle latency.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - An operation is accepted on an edge where in_valid && in_ready; operands are sampled only then.
  - in_valid while in_ready=0 is ignored; upstream holds its inputs.
- Single-cycle ops: accepted at edge E0; out_valid=1 with result/zero/illegal after E0. With out_ready tied high, throughput is 1 op per clock.
- Output hold: while out_valid && !out_ready, result/zero/illegal/flags stay stable. out_valid clears on an edge with out_ready=1 and no new completion.
- Simultaneous drain and accept on the same edge: output is overwritten by the new result; out_valid stays 1.
- FSM:
  - IDLE → BUSY on MUL accept; load multiplicand, multiplier and counter=WIDTH; busy=1.
  - BUSY: each cycle, if multiplier LSB=1, add multiplicand to the accumulator; shift multiplicand left and multiplier right; decrement counter.
  - When counter reaches 1, write the accumulator to result and set out_valid; → IDLE.
  - MUL latency is WIDTH cycles, from accept edge E0 to out_valid after edge E_WIDTH.
- zero is computed from the value being written to result, registered on the same edge. It is never combinational on the result output.
- Zero-operand MUL still takes WIDTH cycles; there is no early exit.

Optional Feature:
- Macro ALU_PIPE_FLAGS_EN.
- Defined: adds outputs carry, overflow and negative (1 bit each), registered with result. Reset value 0.
  - ADD: carry = carry-out.
  - SUB: carry = 1 iff input1 >= input2 unsigned (no borrow).
  - ADD/SUB: overflow = signed overflow.
  - negative = result[WIDTH-1] for all ops.
  - AND/OR/NOR/SLT/MUL/illegal: carry=0, overflow=0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package alu_pkg: opcode localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MUL), state enum (IDLE, BUSY), and function is_legal_op.
- Sub-module alu_seq_mul: shift-add multiplier with start/done, parametrised by WIDTH. The top owns the handshake and output register.

Test Plan:
- Reset then idle → out_valid=0, result=0, zero=0, in_ready=1. Assert rst mid-MUL → no out_valid; in_ready=1 on the next cycle.
- Back-to-back ADD 5+7, SUB 7-7, AND 0xF0&0x0F, out_ready=1 → results 12/z0, 0/z1, 0/z1 on consecutive cycles.
- SLT input1=-1 (all ones), input2=1 → result=1. Swap operands → result=0. NOR 0,0 → all ones.
- MUL 12*13 at WIDTH=64 → busy for 64 cycles, in_ready=0 throughout, result=156 exactly 64 cycles after accept. Run at WIDTH=8: 0xFF*0x02 → 0xFE.
- Backpressure: out_ready=0 for 5 cycles after an ADD completes → result stable, in_ready=0. Release → a same-edge accept of the next op produces no gap.
- select=0011 → illegal=1, result=0, zero=1. With ALU_PIPE_FLAGS_EN: ADD 0x7FFF..F+1 → overflow=1, negative=1, carry=0; SUB 0-1 → carry=0.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the pipelined ALU (alu_pipe) and its sequential
// multiplier (alu_seq_mul).
//   - OPC_W       : width of the decoded opcode field (4 bits)
//   - OP_*        : supported opcodes
//   - state_t     : multiply sequencer state (IDLE / BUSY)
//   - is_legal_op : 1 iff the opcode is in the supported set
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_AND = 4'b0000;
  localparam logic [OPC_W-1:0] OP_OR  = 4'b0001;
  localparam logic [OPC_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OPC_W-1:0] OP_SUB = 4'b0110;
  localparam logic [OPC_W-1:0] OP_SLT = 4'b0111;
  localparam logic [OPC_W-1:0] OP_NOR = 4'b1100;
  localparam logic [OPC_W-1:0] OP_MUL = 4'b1000;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic is_legal_op(input logic [OPC_W-1:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MUL: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// -----------------------------------------------------------------------------
// alu_seq_mul
// Shift-add multiplier producing the low WIDTH bits of the unsigned product.
// One partial product per clock; always WIDTH cycles, no early exit.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset (aborts a multiply)
//   start         : load operands (honoured only in IDLE)
//   multiplicand  : operand A, sampled on the start edge
//   multiplier    : operand B, sampled on the start edge
//   done          : combinational, high in the last BUSY cycle; product is
//                   valid in that same cycle and is meant to be registered
//                   by the caller on that edge
//   product       : low WIDTH bits of multiplicand * multiplier
//   state         : sequencer state, exported for debug and for busy/ready
// -----------------------------------------------------------------------------
module alu_seq_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output state_t           state
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mlier_q, mlier_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] acc_step;

  // Accumulator after this cycle's partial product; on the final cycle this
  // is the full product, so it is handed out directly rather than registered
  // here a second time.
  assign acc_step = acc_q + (mlier_q[0] ? mcand_q : '0);
  assign product  = acc_step;
  assign state    = state_q;

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mlier_d = mlier_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          mcand_d = multiplicand;
          mlier_d = multiplier;
          acc_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
        end
      end
      BUSY: begin
        acc_d   = acc_step;
        mcand_d = mcand_q << 1;
        mlier_d = mlier_q >> 1;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mlier_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mlier_q <= mlier_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Registered ALU with valid/ready handshakes, sitting between operand fetch
// and writeback. Single-cycle ops: AND, OR, ADD, SUB, SLT (signed), NOR.
// MUL runs WIDTH cycles in alu_seq_mul. Unsupported opcodes complete in one
// cycle with result=0, zero=1, illegal=1.
//
// Handshake: a transfer happens on an edge where valid && ready on that side.
// in_ready = (state==IDLE) && (!out_valid || out_ready); operands are sampled
// only on an accepting edge. While out_valid && !out_ready the output register
// (result, zero, illegal, flags) holds. A completion on the same edge as a
// drain overwrites the output and out_valid stays 1.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operation handshake
//   select              : opcode (SEL_W bits)
//   input1, input2      : operands A, B
//   out_valid/out_ready : result handshake
//   result, zero        : registered result and (result == 0)
//   illegal             : registered, opcode was not supported
//   busy                : multiply in progress
//   carry, overflow,
//   negative            : only when ALU_PIPE_FLAGS_EN is defined
//
// Build option: define ALU_PIPE_FLAGS_EN to add the carry/overflow/negative
// outputs.
// -----------------------------------------------------------------------------
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] select,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             busy
`ifdef ALU_PIPE_FLAGS_EN
  ,
  output logic             carry,
  output logic             overflow,
  output logic             negative
`endif
);

  // Opcode decode. Any set bit above the 4-bit opcode field makes the code
  // unsupported, whatever the low bits say.
  logic [31:0]      sel_ext;
  logic [OPC_W-1:0] op;
  logic             op_legal;
  logic             op_mul;

  assign sel_ext  = 32'(select);
  assign op       = sel_ext[OPC_W-1:0];
  assign op_legal = (sel_ext[31:OPC_W] == '0) && is_legal_op(op);
  assign op_mul   = op_legal && (op == OP_MUL);

  // Handshake
  state_t mul_state;
  logic   accept;
  logic   single_done;

  assign in_ready    = (mul_state == IDLE) && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign single_done = accept && !op_mul;
  assign busy        = (mul_state == BUSY);

  // Multiplier
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  alu_seq_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk          (clk),
    .rst          (rst),
    .start        (accept && op_mul),
    .multiplicand (input1),
    .multiplier   (input2),
    .done         (mul_done),
    .product      (mul_product),
    .state        (mul_state)
  );

  // Add/sub datapath. With flags enabled the extra carry bit is kept.
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
`ifdef ALU_PIPE_FLAGS_EN
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  assign add_full = {1'b0, input1} + {1'b0, input2};
  assign sub_full = {1'b0, input1} - {1'b0, input2};
  assign add_res  = add_full[WIDTH-1:0];
  assign sub_res  = sub_full[WIDTH-1:0];
`else
  assign add_res  = input1 + input2;
  assign sub_res  = input1 - input2;
`endif

  logic [WIDTH-1:0] op_res;
`ifdef ALU_PIPE_FLAGS_EN
  logic             op_carry;
  logic             op_ovf;
`endif

  always_comb begin
    op_res = '0;
`ifdef ALU_PIPE_FLAGS_EN
    op_carry = 1'b0;
    op_ovf   = 1'b0;
`endif
    case (op)
      OP_AND: op_res = input1 & input2;
      OP_OR:  op_res = input1 | input2;
      OP_NOR: op_res = ~(input1 | input2);
      OP_SLT: op_res = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
      OP_ADD: begin
        op_res = add_res;
`ifdef ALU_PIPE_FLAGS_EN
        op_carry = add_full[WIDTH];
        op_ovf   = (input1[WIDTH-1] == input2[WIDTH-1]) &&
                   (add_res[WIDTH-1] != input1[WIDTH-1]);
`endif
      end
      OP_SUB: begin
        op_res = sub_res;
`ifdef ALU_PIPE_FLAGS_EN
        // Carry means "no borrow", i.e. input1 >= input2 unsigned.
        op_carry = !sub_full[WIDTH];
        op_ovf   = (input1[WIDTH-1] != input2[WIDTH-1]) &&
                   (sub_res[WIDTH-1] != input1[WIDTH-1]);
`endif
      end
      default: op_res = '0;
    endcase
    if (!op_legal) begin
      op_res = '0;
`ifdef ALU_PIPE_FLAGS_EN
      op_carry = 1'b0;
      op_ovf   = 1'b0;
`endif
    end
  end

  // Output register. Single-cycle completions and multiply completions cannot
  // coincide: a multiply completes only in BUSY, when nothing is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
`ifdef ALU_PIPE_FLAGS_EN
      carry     <= 1'b0;
      overflow  <= 1'b0;
      negative  <= 1'b0;
`endif
    end else if (single_done) begin
      out_valid <= 1'b1;
      result    <= op_res;
      zero      <= (op_res == '0);
      illegal   <= !op_legal;
`ifdef ALU_PIPE_FLAGS_EN
      carry     <= op_carry;
      overflow  <= op_ovf;
      negative  <= op_res[WIDTH-1];
`endif
    end else if (mul_done) begin
      out_valid <= 1'b1;
      result    <= mul_product;
      zero      <= (mul_product == '0);
      illegal   <= 1'b0;
`ifdef ALU_PIPE_FLAGS_EN
      carry     <= 1'b0;
      overflow  <= 1'b0;
      negative  <= mul_product[WIDTH-1];
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
// Directed bench for alu_pipe: a 64-bit instance for most scenarios and an
// 8-bit instance for the narrow multiply. Define ALU_PIPE_FLAGS_EN to also
// exercise carry/overflow/negative.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

  localparam int W  = 64;
  localparam int W8 = 8;

  logic          clk = 1'b0;
  logic          rst;

  logic          in_valid, in_ready, out_valid, out_ready;
  logic [3:0]    select;
  logic [W-1:0]  input1, input2, result;
  logic          zero, illegal, busy;

  logic          in_valid8, in_ready8, out_valid8, out_ready8;
  logic [3:0]    select8;
  logic [W8-1:0] input1_8, input2_8, result8;
  logic          zero8, illegal8, busy8;

`ifdef ALU_PIPE_FLAGS_EN
  logic carry, overflow, negative;
  logic carry8, overflow8, negative8;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .SEL_W(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .select(select), .input1(input1), .input2(input2),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal), .busy(busy)
`ifdef ALU_PIPE_FLAGS_EN
    , .carry(carry), .overflow(overflow), .negative(negative)
`endif
  );

  alu_pipe #(.WIDTH(W8), .SEL_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .select(select8), .input1(input1_8), .input2(input2_8),
    .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
    .zero(zero8), .illegal(illegal8), .busy(busy8)
`ifdef ALU_PIPE_FLAGS_EN
    , .carry(carry8), .overflow(overflow8), .negative(negative8)
`endif
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [3:0] sel, input logic [W-1:0] a,
                          input logic [W-1:0] b);
    in_valid = 1'b1;
    select   = sel;
    input1   = a;
    input2   = b;
  endtask

  task automatic go_idle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (result !== '0) begin failures++; $display("FAIL reset_result: got %h expected 0", result); end
    checks++;
    if (zero !== 1'b0) begin failures++; $display("FAIL reset_zero: got %b expected 0", zero); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (busy !== 1'b0 || illegal !== 1'b0) begin failures++; $display("FAIL reset_busy_illegal: got %b%b expected 00", busy, illegal); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive_op(4'b0010, 64'd5, 64'd7);
    step();
    drive_op(4'b0110, 64'd7, 64'd7);
    checks++;
    if (out_valid !== 1'b1 || result !== 64'd12 || zero !== 1'b0) begin
      failures++; $display("FAIL b2b_add: got v=%b r=%0d z=%b expected v=1 r=12 z=0", out_valid, result, zero);
    end
    step();
    drive_op(4'b0000, 64'hF0, 64'h0F);
    checks++;
    if (out_valid !== 1'b1 || result !== 64'd0 || zero !== 1'b1) begin
      failures++; $display("FAIL b2b_sub: got v=%b r=%0d z=%b expected v=1 r=0 z=1", out_valid, result, zero);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 64'd0 || zero !== 1'b1) begin
      failures++; $display("FAIL b2b_and: got v=%b r=%0d z=%b expected v=1 r=0 z=1", out_valid, result, zero);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain: got out_valid=%b expected 0", out_valid); end
  endtask

  task automatic test_slt_nor();
    out_ready = 1'b1;
    drive_op(4'b0111, {W{1'b1}}, 64'd1);
    step();
    drive_op(4'b0111, 64'd1, {W{1'b1}});
    checks++;
    if (result !== 64'd1 || zero !== 1'b0) begin failures++; $display("FAIL slt_neg: got r=%h z=%b expected r=1 z=0", result, zero); end
    step();
    drive_op(4'b1100, 64'd0, 64'd0);
    checks++;
    if (result !== 64'd0 || zero !== 1'b1) begin failures++; $display("FAIL slt_swap: got r=%h z=%b expected r=0 z=1", result, zero); end
    step();
    drive_op(4'b0001, 64'hA0, 64'h05);
    checks++;
    if (result !== {W{1'b1}} || zero !== 1'b0) begin failures++; $display("FAIL nor_zero: got r=%h z=%b expected all ones z=0", result, zero); end
    step();
    in_valid = 1'b0;
    checks++;
    if (result !== 64'hA5) begin failures++; $display("FAIL or: got r=%h expected a5", result); end
    go_idle();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    drive_op(4'b0011, 64'd9, 64'd9);
    step();
    drive_op(4'b0010, 64'd1, 64'd1);
    checks++;
    if (out_valid !== 1'b1 || illegal !== 1'b1 || result !== '0 || zero !== 1'b1) begin
      failures++; $display("FAIL illegal_op: got v=%b ill=%b r=%h z=%b expected v=1 ill=1 r=0 z=1", out_valid, illegal, result, zero);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (illegal !== 1'b0 || result !== 64'd2) begin
      failures++; $display("FAIL illegal_clear: got ill=%b r=%h expected ill=0 r=2", illegal, result);
    end
    go_idle();
  endtask

  task automatic test_mul();
    logic bad;
    out_ready = 1'b1;
    drive_op(4'b1000, 64'd12, 64'd13);
    step();
    in_valid = 1'b0;
    bad = 1'b0;
    // After accept edge E0 up to after E63: busy, not ready, nothing out.
    for (int i = 0; i < W; i++) begin
      if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
      step();
    end
    checks++;
    if (bad !== 1'b0) begin failures++; $display("FAIL mul_busy_window: got bad=%b expected 0", bad); end
    checks++;
    if (out_valid !== 1'b1 || result !== 64'd156 || zero !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL mul_result: got v=%b r=%0d z=%b busy=%b expected v=1 r=156 z=0 busy=0", out_valid, result, zero, busy);
    end
    go_idle();
  endtask

  task automatic test_mul8();
    logic bad;
    out_ready8 = 1'b1;
    in_valid8  = 1'b1;
    select8    = 4'b1000;
    input1_8   = 8'hFF;
    input2_8   = 8'h02;
    step();
    in_valid8 = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < W8; i++) begin
      if (out_valid8 !== 1'b0 || busy8 !== 1'b1) bad = 1'b1;
      step();
    end
    checks++;
    if (bad !== 1'b0) begin failures++; $display("FAIL mul8_window: got bad=%b expected 0", bad); end
    checks++;
    if (out_valid8 !== 1'b1 || result8 !== 8'hFE) begin
      failures++; $display("FAIL mul8_result: got v=%b r=%h expected v=1 r=fe", out_valid8, result8);
    end
    step();
    step();
  endtask

  task automatic test_backpressure();
    logic bad;
    out_ready = 1'b0;
    drive_op(4'b0010, 64'd3, 64'd4);
    step();
    drive_op(4'b0110, 64'd10, 64'd2);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || result !== 64'd7 || in_ready !== 1'b0) bad = 1'b1;
      step();
    end
    checks++;
    if (bad !== 1'b0) begin failures++; $display("FAIL bp_hold: got bad=%b expected 0", bad); end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 64'd8) begin
      failures++; $display("FAIL bp_no_gap: got v=%b r=%0d expected v=1 r=8", out_valid, result);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid_mul();
    logic bad;
    out_ready = 1'b1;
    drive_op(4'b1000, 64'd3, 64'd3);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_mid_mul: got busy=%b rdy=%b v=%b expected 0 1 0", busy, in_ready, out_valid);
    end
    bad = 1'b0;
    for (int i = 0; i < W + 6; i++) begin
      if (out_valid !== 1'b0) bad = 1'b1;
      step();
    end
    checks++;
    if (bad !== 1'b0) begin failures++; $display("FAIL rst_mid_mul_no_result: got bad=%b expected 0", bad); end
  endtask

`ifdef ALU_PIPE_FLAGS_EN
  task automatic test_flags();
    out_ready = 1'b1;
    drive_op(4'b0010, {1'b0, {(W-1){1'b1}}}, 64'd1);
    step();
    drive_op(4'b0110, 64'd0, 64'd1);
    checks++;
    if (overflow !== 1'b1 || negative !== 1'b1 || carry !== 1'b0) begin
      failures++; $display("FAIL flags_add_ovf: got c=%b v=%b n=%b expected c=0 v=1 n=1", carry, overflow, negative);
    end
    step();
    drive_op(4'b0110, 64'd5, 64'd3);
    checks++;
    if (carry !== 1'b0 || overflow !== 1'b0 || negative !== 1'b1) begin
      failures++; $display("FAIL flags_sub_borrow: got c=%b v=%b n=%b expected c=0 v=0 n=1", carry, overflow, negative);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (carry !== 1'b1 || overflow !== 1'b0 || negative !== 1'b0) begin
      failures++; $display("FAIL flags_sub_noborrow: got c=%b v=%b n=%b expected c=1 v=0 n=0", carry, overflow, negative);
    end
    go_idle();
  endtask
`endif

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    select     = '0;
    input1     = '0;
    input2     = '0;
    in_valid8  = 1'b0;
    out_ready8 = 1'b1;
    select8    = '0;
    input1_8   = '0;
    input2_8   = '0;

    test_reset();
    test_back_to_back();
    test_slt_nor();
    test_illegal();
    test_mul();
    test_mul8();
    test_backpressure();
    test_reset_mid_mul();
`ifdef ALU_PIPE_FLAGS_EN
    test_flags();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
